// File: rtl/fifo_slice_pkg.sv
// Shared types and elaboration helpers for the FIFO slice reader.
package fifo_slice_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY,
    ST_BUSY
  } state_e;

  function automatic int unsigned calc_nslice(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // A single-slice entry would still need a 1-bit index to keep ports legal
  function automatic int unsigned calc_idxw(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/fifo_slice_reader_if.sv
// Slice stream toward the SIMD lane datapath: valid/ready with slice index and last flag.
interface fifo_slice_reader_if
  import fifo_slice_pkg::*;
#(
  parameter int unsigned SLICE = 31,
  parameter int unsigned IDXW  = calc_idxw(calc_nslice(248, 31))
) ();

  logic             valid;
  logic [SLICE-1:0] data;
  logic [IDXW-1:0]  index;
  logic             last;
  logic             ready;

  modport master (output valid, data, index, last, input ready);
  modport slave  (input valid, data, index, last, output ready);

endinterface

// File: rtl/fifo_slice_reader.sv
// Pops WIDTH-bit entries from a show-ahead FIFO and emits them as NSLICE slices, lowest first,
// reloading on the last accepted slice so consecutive entries stream without a bubble.
module fifo_slice_reader
  import fifo_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 248,
  parameter int unsigned SLICE = 31,
  parameter int unsigned CNTW  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [WIDTH-1:0]           i_fifo_data,
  input  logic                       i_fifo_empty,
  output logic                       o_fifo_read,
  output logic [CNTW-1:0]            o_word_count,
  fifo_slice_reader_if.master        stream
);

  localparam int unsigned NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int unsigned IDXW   = calc_idxw(NSLICE);
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("fifo_slice_reader: WIDTH must be a multiple of SLICE");
  end
  if (NSLICE < 2) begin : g_bad_nslice
    $error("fifo_slice_reader: WIDTH/SLICE must be at least 2");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  word_q, word_d;

  logic busy;
  logic last;
  logic accept;
  logic can_load;

  // State register
  always_ff @(posedge i_clk) begin : p_state
    if (i_rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held entry is data only; a reset simply abandons it
  always_ff @(posedge i_clk) begin : p_word
    word_q <= word_d;
  end

  // Next state: a load overrides the advance/retire of the final slice in the same cycle
  always_comb begin : p_next
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (accept) begin
      if (last) begin
        cnt_d   = cnt_q + CNTW'(1);
        state_d = ST_EMPTY;
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end
    if (o_fifo_read) begin
      word_d  = i_fifo_data;
      idx_d   = '0;
      state_d = ST_BUSY;
    end
  end

  // Outputs: everything but the pop strobe comes straight from registers
  always_comb begin : p_out
    busy         = (state_q == ST_BUSY);
    last         = busy & (idx_q == LastIdx);
    accept       = busy & stream.ready;
    can_load     = (state_q == ST_EMPTY) | (accept & last);
    o_fifo_read  = can_load & ~i_fifo_empty & ~i_rst;
    o_word_count = cnt_q;
    stream.valid = busy;
    stream.data  = word_q[SLICE*idx_q +: SLICE];
    stream.index = idx_q;
    stream.last  = last;
  end

endmodule

// File: tb/tb_fifo_slice_reader.sv
// Scoreboard bench for fifo_slice_reader: a queue-backed show-ahead FIFO model feeds the DUT,
// expected slices are queued at push time and checked by a monitor on every accept.
module tb_fifo_slice_reader;

  localparam int W    = 248;
  localparam int S    = 31;
  localparam int N    = 8;
  localparam int CNTW = 4;

  typedef struct {
    logic [S-1:0] data;
    int           idx;
    logic         last;
  } slice_t;

  logic            clk;
  logic            rst;
  logic [W-1:0]    fifo_data;
  logic            fifo_empty;
  logic            fifo_read;
  logic [CNTW-1:0] wc;

  fifo_slice_reader_if #(.SLICE(S), .IDXW(3)) stream ();

  fifo_slice_reader #(
    .WIDTH(W),
    .SLICE(S),
    .CNTW (CNTW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_fifo_data (fifo_data),
    .i_fifo_empty(fifo_empty),
    .o_fifo_read (fifo_read),
    .o_word_count(wc),
    .stream      (stream)
  );

  logic [W-1:0] fifo_q[$];
  slice_t       exp_q[$];
  int           n_pass  = 0;
  int           n_total = 0;
  int           n_reads = 0;
  logic         pop_pend = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic void refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endfunction

  function automatic logic [W-1:0] make_entry(input int base);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[k*S +: S] = S'(base + k);
    return w;
  endfunction

  task automatic push_entry(input int base);
    slice_t s;
    fifo_q.push_back(make_entry(base));
    for (int k = 0; k < N; k++) begin
      s.data = S'(base + k);
      s.idx  = k;
      s.last = (k == N - 1);
      exp_q.push_back(s);
    end
    refresh();
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read on the falling edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // FIFO advances just after the edge at which it was popped
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        refresh();
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    slice_t e;
    pop_pend = fifo_read;
    if (fifo_read) n_reads++;
    check("pop_when_empty", {63'd0, fifo_read & fifo_empty}, 64'd0);
    if (rst) begin
      while (exp_q.size() != 0 && exp_q[0].idx != 0) void'(exp_q.pop_front());
    end else if (stream.valid && stream.ready) begin
      check("sb_expected_slice", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_data", 64'(stream.data), 64'(e.data));
        check("sb_index", 64'(stream.index), 64'(e.idx));
        check("sb_last", {63'd0, stream.last}, {63'd0, e.last});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gaps;
    int   reads0;
    logic done;

    rst          = 1'b1;
    stream.ready = 1'b1;
    refresh();

    // Reset
    repeat (2) begin
      sample();
      check("rst_read", {63'd0, fifo_read}, 64'd0);
      check("rst_valid", {63'd0, stream.valid}, 64'd0);
      cyc();
    end
    rst = 1'b0;
    sample();
    check("rst_wc", 64'(wc), 64'd0);
    check("rst_index", 64'(stream.index), 64'd0);

    // One entry, slices 1..8
    cyc();
    push_entry(1);
    sample();
    check("t1_pop", {63'd0, fifo_read}, 64'd1);
    for (int k = 0; k < N; k++) begin
      cyc();
      sample();
      check("t1_valid", {63'd0, stream.valid}, 64'd1);
      check("t1_data", 64'(stream.data), 64'(k + 1));
      check("t1_index", 64'(stream.index), 64'(k));
      check("t1_last", {63'd0, stream.last}, {63'd0, k == N - 1});
    end
    cyc();
    sample();
    check("t1_valid_off", {63'd0, stream.valid}, 64'd0);
    check("t1_wc", 64'(wc), 64'd1);
    check("t1_reads", 64'(n_reads), 64'd1);

    // Back-to-back, three entries queued
    cyc();
    push_entry(16);
    push_entry(32);
    push_entry(48);
    sample();
    check("t2_pop_first", {63'd0, fifo_read}, 64'd1);
    gaps = 0;
    for (int c = 1; c <= 3 * N; c++) begin
      cyc();
      sample();
      if (!stream.valid) gaps++;
      if (c % N == 0) check("t2_pop_at_last", {63'd0, fifo_read}, {63'd0, c < 3 * N});
      else check("t2_no_pop", {63'd0, fifo_read}, 64'd0);
    end
    check("t2_gaps", 64'(gaps), 64'd0);
    cyc();
    sample();
    check("t2_valid_off", {63'd0, stream.valid}, 64'd0);
    check("t2_wc", 64'(wc), 64'd4);

    // Backpressure at idx 3
    cyc();
    push_entry(64);
    sample();
    repeat (4) cyc();
    stream.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("t3_hold_valid", {63'd0, stream.valid}, 64'd1);
      check("t3_hold_index", 64'(stream.index), 64'd3);
      check("t3_hold_data", 64'(stream.data), 64'd67);
      check("t3_hold_no_pop", {63'd0, fifo_read}, 64'd0);
      cyc();
    end
    stream.ready = 1'b1;
    sample();
    check("t3_release_index", 64'(stream.index), 64'd3);
    cyc();
    sample();
    check("t3_resume_index", 64'(stream.index), 64'd4);
    check("t3_resume_data", 64'(stream.data), 64'd68);

    // Last slice accepted with the FIFO empty
    repeat (3) cyc();
    sample();
    check("t4_last", {63'd0, stream.last}, 64'd1);
    check("t4_no_pop", {63'd0, fifo_read}, 64'd0);
    cyc();
    sample();
    check("t4_valid_off", {63'd0, stream.valid}, 64'd0);
    check("t4_no_pop_idle", {63'd0, fifo_read}, 64'd0);
    cyc();
    push_entry(80);
    sample();
    check("t4_pop_on_arrival", {63'd0, fifo_read}, 64'd1);
    cyc();
    sample();
    check("t4_valid_on", {63'd0, stream.valid}, 64'd1);
    check("t4_index0", 64'(stream.index), 64'd0);
    repeat (N) cyc();
    sample();
    check("t4_valid_off2", {63'd0, stream.valid}, 64'd0);
    check("t4_wc", 64'(wc), 64'd6);

    // Reset mid-entry at idx 5
    cyc();
    push_entry(96);
    push_entry(112);
    sample();
    repeat (6) cyc();
    rst = 1'b1;
    sample();
    check("t5_rst_index", 64'(stream.index), 64'd5);
    check("t5_rst_no_pop", {63'd0, fifo_read}, 64'd0);
    cyc();
    sample();
    check("t5_valid_off", {63'd0, stream.valid}, 64'd0);
    check("t5_wc", 64'(wc), 64'd0);
    check("t5_rst_no_pop2", {63'd0, fifo_read}, 64'd0);
    cyc();
    rst = 1'b0;
    sample();
    check("t5_pop_after", {63'd0, fifo_read}, 64'd1);
    cyc();
    sample();
    check("t5_next_index", 64'(stream.index), 64'd0);
    check("t5_next_data", 64'(stream.data), 64'd112);
    repeat (N) cyc();
    sample();
    check("t5_wc_after", 64'(wc), 64'd1);

    // Counter wrap: 17 entries into a 4-bit counter
    cyc();
    rst = 1'b1;
    cyc();
    rst    = 1'b0;
    reads0 = n_reads;
    for (int i = 0; i < 17; i++) push_entry(i * 8 + 200);
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      cyc();
      sample();
      if (!stream.valid && fifo_empty) begin
        done = 1'b1;
        break;
      end
    end
    check("t6_drained", {63'd0, done}, 64'd1);
    check("t6_wc_wrap", 64'(wc), 64'd1);
    check("t6_reads", 64'(n_reads - reads0), 64'd17);

    cyc();
    check("sb_all_consumed", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
